coastal_risk_fsm: RTL and testbench

Parametrised successor to the three-state coastal warning controller. Takes N individual hazard flags (wave height, flood, tide, erosion, runoff, debris, …) and counts active sensors itself; it no longer receives pre-reduced OR/AND terms. Adds dwell-time hysteresis, a recovery state, a latched crisis alarm with operator acknowledge, and a saturating crisis-event counter. Sits between the sensor-conditioning front end and the alert/telemetry output stage.

---
 rtl/coastal_risk_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_coastal_risk_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/coastal_risk_fsm.sv
// coastal_risk_fsm
// Four-state coastal hazard controller (NORMAL / WASPADA / KRISIS / PEMULIHAN).
// Counts the active hazard flags, applies dwell-time hysteresis on the way up
// to WASPADA and on the way down, keeps a sticky crisis alarm with operator
// acknowledge, and counts crisis entries up to a saturation limit of 255.
//
// Optional feature macro: COASTAL_SENSOR_MASK_EN
//   defined   -> sensor_mask port exists; masked sensors are not counted
//   undefined -> no sensor_mask port; every sensor is counted
//
// Every output comes from a flop. There is no combinational path from risk
// or ack to any output.

module coastal_risk_fsm #(
   parameter int N_SENSORS   = 6,
   parameter int CRIT_MIN    = N_SENSORS,
   parameter int ALERT_DWELL = 4,
   parameter int CLEAR_DWELL = 8,
   parameter int DWELL_W     = 8
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [N_SENSORS-1:0]               risk,
`ifdef COASTAL_SENSOR_MASK_EN
   input  logic [N_SENSORS-1:0]               sensor_mask,
`endif
   input  logic                               ack,
   output logic [1:0]                         state,
   output logic                               O_Kritis,
   output logic                               O_Investigasi,
   output logic [$clog2(N_SENSORS+1)-1:0]     active_count,
   output logic                               alarm_latched,
   output logic [7:0]                         crisis_events
);

   // Width of the active-sensor count
   localparam int CW = $clog2(N_SENSORS + 1);

   // State encoding; these values also appear on the state port
   localparam logic [1:0] ST_NORMAL    = 2'd0;
   localparam logic [1:0] ST_WASPADA   = 2'd1;
   localparam logic [1:0] ST_KRISIS    = 2'd2;
   localparam logic [1:0] ST_PEMULIHAN = 2'd3;

   // Thresholds converted to the widths of the signals they are compared with.
   // A dwell expires on the edge where the counter would reach the dwell
   // length, so each comparison uses the last count value before that.
   localparam logic [CW-1:0]      CRIT_MIN_C   = CW'(CRIT_MIN);
   localparam logic [DWELL_W-1:0] ALERT_LAST_C = DWELL_W'(ALERT_DWELL - 1);
   localparam logic [DWELL_W-1:0] CLEAR_LAST_C = DWELL_W'(CLEAR_DWELL - 1);
   localparam logic [DWELL_W-1:0] DWELL_ZERO_C = {DWELL_W{1'b0}};
   localparam logic [7:0]         EVENTS_MAX_C = 8'd255;

   // Count the set bits of the counted hazard vector
   function automatic logic [CW-1:0] popcount(input logic [N_SENSORS-1:0] v);
      logic [CW-1:0] acc;
      acc = {CW{1'b0}};
      for (int i = 0; i < N_SENSORS; i++) begin
         acc = acc + CW'(v[i]);
      end
      return acc;
   endfunction

   // Increment the dwell counter but hold it at all-ones instead of wrapping
   function automatic logic [DWELL_W-1:0] dwell_inc(input logic [DWELL_W-1:0] v);
      logic [DWELL_W-1:0] r;
      if (v == {DWELL_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + DWELL_W'(1);
      end
      return r;
   endfunction

   // Per-cycle hazard terms
   logic [N_SENSORS-1:0] mask_s;
   logic [N_SENSORS-1:0] counted_s;
   logic [CW-1:0]        cnt_s;
   logic                 any_s;
   logic                 crit_s;
   logic                 krisis_entry_s;

   // Registered state and its next-state values
   logic [1:0]         state_q,         state_d;
   logic [DWELL_W-1:0] dwell_q,         dwell_d;
   logic               kritis_q,        kritis_d;
   logic               investigasi_q,   investigasi_d;
   logic [CW-1:0]      active_count_q,  active_count_d;
   logic               alarm_q,         alarm_d;
   logic [7:0]         events_q,        events_d;

`ifdef COASTAL_SENSOR_MASK_EN
   assign mask_s = sensor_mask;
`else
   assign mask_s = {N_SENSORS{1'b1}};
`endif

   // Reduce the sensor flags to the count, any and crit terms
   always_comb begin
      counted_s = risk & mask_s;
      cnt_s     = popcount(counted_s);
      any_s     = (cnt_s != {CW{1'b0}});
      crit_s    = (cnt_s >= CRIT_MIN_C);
   end

   // Next-state and dwell-counter logic (priority: crit, dwell expiry, hold)
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      case (state_q)
         ST_NORMAL: begin
            if (crit_s) begin
               state_d = ST_KRISIS;
               dwell_d = DWELL_ZERO_C;
            end else if (any_s) begin
               if (dwell_q >= ALERT_LAST_C) begin
                  state_d = ST_WASPADA;
                  dwell_d = DWELL_ZERO_C;
               end else begin
                  state_d = ST_NORMAL;
                  dwell_d = dwell_inc(dwell_q);
               end
            end else begin
               // A quiet cycle breaks the run of risky cycles
               state_d = ST_NORMAL;
               dwell_d = DWELL_ZERO_C;
            end
         end
         ST_WASPADA: begin
            if (crit_s) begin
               state_d = ST_KRISIS;
               dwell_d = DWELL_ZERO_C;
            end else if (!any_s) begin
               if (dwell_q >= CLEAR_LAST_C) begin
                  state_d = ST_NORMAL;
                  dwell_d = DWELL_ZERO_C;
               end else begin
                  state_d = ST_WASPADA;
                  dwell_d = dwell_inc(dwell_q);
               end
            end else begin
               // Any active sensor restarts the clear-down interval
               state_d = ST_WASPADA;
               dwell_d = DWELL_ZERO_C;
            end
         end
         ST_KRISIS: begin
            if (crit_s) begin
               state_d = ST_KRISIS;
               dwell_d = DWELL_ZERO_C;
            end else begin
               state_d = ST_PEMULIHAN;
               dwell_d = DWELL_ZERO_C;
            end
         end
         ST_PEMULIHAN: begin
            if (crit_s) begin
               state_d = ST_KRISIS;
               dwell_d = DWELL_ZERO_C;
            end else if (dwell_q >= CLEAR_LAST_C) begin
               // Recovery over: residual risk lands in WASPADA, none in NORMAL
               if (any_s) begin
                  state_d = ST_WASPADA;
               end else begin
                  state_d = ST_NORMAL;
               end
               dwell_d = DWELL_ZERO_C;
            end else begin
               // Recovery time runs regardless of sub-critical risk
               state_d = ST_PEMULIHAN;
               dwell_d = dwell_inc(dwell_q);
            end
         end
         default: begin
            // Unreachable with a 2-bit state; recover to the safe state
            state_d = ST_NORMAL;
            dwell_d = DWELL_ZERO_C;
         end
      endcase
   end

   // Output decode of the next state so the output flops track state_q exactly
   always_comb begin
      krisis_entry_s = (state_d == ST_KRISIS) && (state_q != ST_KRISIS);
      kritis_d       = (state_d == ST_KRISIS);
      investigasi_d  = (state_d == ST_WASPADA) || (state_d == ST_PEMULIHAN);
      active_count_d = cnt_s;
   end

   // Sticky alarm: set on KRISIS entry, cleared by ack outside KRISIS, set wins
   always_comb begin
      if (krisis_entry_s) begin
         alarm_d = 1'b1;
      end else if (ack && (state_q != ST_KRISIS)) begin
         alarm_d = 1'b0;
      end else begin
         alarm_d = alarm_q;
      end
   end

   // Crisis-entry counter that stops at 255
   always_comb begin
      if (krisis_entry_s && (events_q != EVENTS_MAX_C)) begin
         events_d = events_q + 8'd1;
      end else begin
         events_d = events_q;
      end
   end

   // State, dwell counter and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_NORMAL;
         dwell_q        <= DWELL_ZERO_C;
         kritis_q       <= 1'b0;
         investigasi_q  <= 1'b0;
         active_count_q <= {CW{1'b0}};
         alarm_q        <= 1'b0;
         events_q       <= 8'd0;
      end else begin
         state_q        <= state_d;
         dwell_q        <= dwell_d;
         kritis_q       <= kritis_d;
         investigasi_q  <= investigasi_d;
         active_count_q <= active_count_d;
         alarm_q        <= alarm_d;
         events_q       <= events_d;
      end
   end

   assign state         = state_q;
   assign O_Kritis      = kritis_q;
   assign O_Investigasi = investigasi_q;
   assign active_count  = active_count_q;
   assign alarm_latched = alarm_q;
   assign crisis_events = events_q;

endmodule

// File: tb/tb_coastal_risk_fsm.sv
// Directed testbench for coastal_risk_fsm with default parameters.
// Expected values are worked out by hand from the intended behaviour.
// The sensor-mask scenario is compiled only with COASTAL_SENSOR_MASK_EN.

module tb_coastal_risk_fsm;

   logic       clk;
   logic       reset_n;
   logic [5:0] risk;
   logic [5:0] sensor_mask;
   logic       ack;
   logic [1:0] state;
   logic       O_Kritis;
   logic       O_Investigasi;
   logic [2:0] active_count;
   logic       alarm_latched;
   logic [7:0] crisis_events;

   int n_checks;
   int n_errors;

   coastal_risk_fsm dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .risk          (risk),
`ifdef COASTAL_SENSOR_MASK_EN
      .sensor_mask   (sensor_mask),
`endif
      .ack           (ack),
      .state         (state),
      .O_Kritis      (O_Kritis),
      .O_Investigasi (O_Investigasi),
      .active_count  (active_count),
      .alarm_latched (alarm_latched),
      .crisis_events (crisis_events)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 ns past the last edge
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b0;
      risk        = 6'h3F;
      sensor_mask = 6'h3F;
      ack         = 1'b0;

      // Reset held with all hazards active
      step(2);
      check_val("rst_state",   32'(state),         32'd0);
      check_val("rst_kritis",  32'(O_Kritis),      32'd0);
      check_val("rst_invest",  32'(O_Investigasi), 32'd0);
      check_val("rst_alarm",   32'(alarm_latched), 32'd0);
      check_val("rst_count",   32'(active_count),  32'd0);
      check_val("rst_events",  32'(crisis_events), 32'd0);

      reset_n = 1'b1;
      risk    = 6'h00;
      step(3);
      check_val("idle_state", 32'(state), 32'd0);

      // Three risky cycles then a quiet one: no WASPADA
      risk = 6'h01;
      step(3);
      check_val("dwell3_state", 32'(state),        32'd0);
      check_val("dwell3_count", 32'(active_count), 32'd1);
      risk = 6'h00;
      step(1);
      check_val("dwell_clr_state", 32'(state), 32'd0);

      // Four risky cycles: WASPADA after the fourth edge
      risk = 6'h01;
      step(3);
      check_val("dwell_pre4", 32'(state), 32'd0);
      step(1);
      check_val("waspada_state",  32'(state),         32'd1);
      check_val("waspada_invest", 32'(O_Investigasi), 32'd1);

      // Eight quiet cycles back to NORMAL
      risk = 6'h00;
      step(7);
      check_val("clear7_state", 32'(state), 32'd1);
      step(1);
      check_val("clear8_state",  32'(state),         32'd0);
      check_val("clear8_invest", 32'(O_Investigasi), 32'd0);

      // Crisis straight from NORMAL
      risk = 6'h3F;
      step(1);
      check_val("krisis_state",  32'(state),         32'd2);
      check_val("krisis_kritis", 32'(O_Kritis),      32'd1);
      check_val("krisis_alarm",  32'(alarm_latched), 32'd1);
      check_val("krisis_events", 32'(crisis_events), 32'd1);
      check_val("krisis_count",  32'(active_count),  32'd6);

      // Ack inside KRISIS is ignored
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      check_val("ack_krisis_alarm", 32'(alarm_latched), 32'd1);
      check_val("ack_krisis_state", 32'(state),         32'd2);

      // Sub-critical risk: PEMULIHAN, then WASPADA after 8 cycles
      risk = 6'h03;
      step(1);
      check_val("pemul_state",  32'(state),         32'd3);
      check_val("pemul_kritis", 32'(O_Kritis),      32'd0);
      check_val("pemul_invest", 32'(O_Investigasi), 32'd1);
      step(7);
      check_val("pemul7_state", 32'(state), 32'd3);
      step(1);
      check_val("pemul8_state", 32'(state), 32'd1);

      // One sensor short of crit from WASPADA: no crisis
      risk = 6'h1F;
      step(1);
      check_val("subcrit_state", 32'(state),        32'd1);
      check_val("subcrit_count", 32'(active_count), 32'd5);

      // WASPADA -> KRISIS -> PEMULIHAN, re-escalate at dwell 5
      risk = 6'h3F;
      step(1);
      check_val("krisis2_events", 32'(crisis_events), 32'd2);
      risk = 6'h00;
      step(1);
      check_val("pemul2_state", 32'(state), 32'd3);
      step(5);
      check_val("pemul2_d5", 32'(state), 32'd3);
      risk = 6'h3F;
      step(1);
      check_val("reesc_state",  32'(state),         32'd2);
      check_val("reesc_events", 32'(crisis_events), 32'd3);

      // Ack in PEMULIHAN clears the alarm
      risk = 6'h00;
      step(1);
      check_val("pemul3_alarm", 32'(alarm_latched), 32'd1);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      check_val("ack_pemul_alarm", 32'(alarm_latched), 32'd0);
      check_val("ack_pemul_state", 32'(state),         32'd3);
      step(6);
      check_val("pemul3_d7", 32'(state), 32'd3);
      step(1);
      check_val("pemul3_normal", 32'(state), 32'd0);

      // Asynchronous reset in KRISIS
      risk = 6'h3F;
      step(1);
      check_val("krisis4_events", 32'(crisis_events), 32'd4);
      reset_n = 1'b0;
      #1;
      check_val("async_state",  32'(state),         32'd0);
      check_val("async_alarm",  32'(alarm_latched), 32'd0);
      check_val("async_events", 32'(crisis_events), 32'd0);
      check_val("async_kritis", 32'(O_Kritis),      32'd0);
      step(1);
      reset_n = 1'b1;
      risk    = 6'h01;
      step(3);
      check_val("post_rst_d3", 32'(state), 32'd0);
      step(1);
      check_val("post_rst_waspada", 32'(state), 32'd1);

      // Crisis counter saturates at 255
      for (int i = 0; i < 300; i++) begin
         risk = 6'h3F;
         step(1);
         risk = 6'h00;
         step(1);
      end
      check_val("events_sat",       32'(crisis_events), 32'd255);
      check_val("events_sat_state", 32'(state),         32'd3);

`ifdef COASTAL_SENSOR_MASK_EN
      // Masked sensor: five counted, no crisis, WASPADA after 4 cycles
      reset_n = 1'b0;
      risk    = 6'h00;
      step(1);
      reset_n     = 1'b1;
      sensor_mask = 6'h3E;
      risk        = 6'h3F;
      step(1);
      check_val("mask_count", 32'(active_count), 32'd5);
      check_val("mask_state", 32'(state),        32'd0);
      step(3);
      check_val("mask_waspada", 32'(state), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
